hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage core, the companion of `forwarding_unit`. It resolves the hazards that forwarding alone cannot cover: load-use, ID-stage branch operands and data-memory wait states. It also owns redirect and trap flushes. For each pipeline register it drives per-stage stall (hold) and flush (bubble) signals. A small FSM tracks data-memory handshakes so that a redirect arriving mid-wait is neither lost nor applied early.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: number of consecutive `MemWait` cycles after which `mem_timeout` asserts.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `forwarding_type_id`, in, `forwarding_type_t`: operand-use class of the instruction in ID.
- `rs1_id`, `rs2_id`, in, 5 each: source registers in ID.
- `rd_ex`, `reg_we_ex`, `mem_rd_en_ex`, `zicsr_ex`, in, 5/1/1/1: the EX instruction's destination, write enable, load flag and CSR-op flag.
- `rd_mem`, `reg_we_mem`, `mem_rd_en_mem`, in, 5/1/1: the MEM instruction's destination, write enable and load flag.
- `flush_req_ex`, in, 1: taken branch or jump resolved in EX.
- `trap_req`, in, 1: trap or `mret` redirect from the CSR bank.
- `mem_req`, in, 1: the MEM stage has an outstanding data-memory access.
- `mem_ack`, in, 1: data memory completes the access this cycle.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, out, 1 each: hold the corresponding pipeline register.
- `flush_id`, `flush_ex`, `flush_mem`, out, 1 each: load a bubble into the corresponding pipeline register.
- `mem_timeout`, out, 1: sticky flag set when a data-memory wait exceeds `MEM_TIMEOUT`.

## Operation
- `match(rs, rd, we)` is defined as `rs == rd && rd != 0 && we`.
- An operand is used in ID when `forwarding_type_id != NoType`.
- **Load-use hazard:** `mem_rd_en_ex`, with `match(rs1_id|rs2_id, rd_ex, reg_we_ex)` and the operand used. Response: `stall_if`, `stall_id`, `flush_ex`.
- **ID-operand hazard** (`forwarding_type_id == Type2`) has three cases:
  - EX holds a non-CSR writer (`reg_we_ex && !zicsr_ex`) matching `rs1_id`.
  - EX holds any writer matching `rs2_id`.
  - MEM holds a load (`mem_rd_en_mem`) matching either operand.
  - Response: same as load-use.
  - A load in EX therefore costs 2 stall cycles, because detection is re-evaluated each cycle.
- **FSM states:**
  - `Run`: default state.
  - `MemWait`: entered when `mem_req && !mem_ack`. While in it, all four stalls assert and all flushes deassert, except for trap handling. Returns to `Run` on `mem_ack`.
- **Pending flush:** `flush_req_ex` seen in `MemWait` sets `flush_pend`. On the ack cycle, `flush_id` and `flush_ex` assert and `flush_pend` clears.
- **Priority**, highest first:
  1. `trap_req`: asserts `flush_id`, `flush_ex` and `flush_mem`, forces `Run`, clears `flush_pend` and the wait counter.
  2. Memory wait.
  3. `flush_req_ex`: asserts `flush_id` and `flush_ex`, and overrides any data-hazard stall that cycle.
  4. Data hazard.
- **Wait counter:**
  - 8-bit saturating counter, or `$clog2(MEM_TIMEOUT+1)` bits; increments each `MemWait` cycle and clears on leaving `MemWait`.
  - `mem_timeout` sets when the count reaches `MEM_TIMEOUT`.
  - `mem_timeout` clears only on `reset` or `trap_req`.

## Timing
- Stall and flush outputs are combinational (Mealy) from the state and current inputs, with zero latency: a hazard and its stall fall in the same cycle.
- Reset values: state `Run`, `flush_pend` 0, wait counter 0, `mem_timeout` 0. All stall and flush outputs are 0 while `reset` is high.
- `mem_req && mem_ack` in the same cycle in `Run` gives no stall and no state change.
- `flush_req_ex` on the same cycle that `mem_ack` ends a wait is treated as pending, so the flush is applied that cycle.
- `reset` mid-wait returns the block to `Run` immediately and drops the pending flush.
- `trap_req` during `MemWait` exits the wait the same cycle. The memory side is responsible for cancelling its request.

## Configuration
- `HAZARD_PERF_EN`: adds output `stall_cycles`, out, 32.
  - The counter increments on every cycle in which `stall_if` is high.
  - It wraps at 2^32 and resets to 0.
- Without the macro, the port and the counter are absent and behaviour is otherwise identical.

## Structure
- `hazard_unit_pkg` holds `hazard_state_t` (`Run`, `MemWait`).
- `forwarding_type_t` is reused from `forwarding_unit_pkg`.
- The `match` helper goes in `hazard_unit_pkg` as a function shared with benches.
- One sub-module, `sat_counter`, is parameterised by width and used for the wait counter.

## Test plan
- Load-use: `mem_rd_en_ex=1`, `rd_ex=5`, `rs1_id=5`, type `Type1` → one cycle of `stall_if=stall_id=flush_ex=1`; repeating with `rd_ex=0` gives no stall.
- Branch after load: `Type2`, `rs2_id=7`, load `rd_ex=7`, which moves to MEM on the next cycle → exactly 2 stall cycles, then clear.
- Memory wait plus redirect: `mem_req=1` and `mem_ack=0` for 4 cycles, with `flush_req_ex` pulsed in cycle 2 → all stalls high for 4 cycles with no flush; at `mem_ack`, `flush_id=flush_ex=1` for one cycle.
- Timeout: `MEM_TIMEOUT=3`, held wait → `mem_timeout` rises after the 3rd wait cycle, stays high after `mem_ack`, and clears on `trap_req`.
- Priority: trap, wait and hazard all asserted → only the three flushes are high, and the FSM returns to `Run`.
- `HAZARD_PERF_EN`: 10 stall cycles → `stall_cycles == 10`; asserting `reset` mid-run → 0.

Source files
------------

// File: rtl/forwarding_unit_pkg.sv
// Shared operand-use classification between forwarding_unit and hazard_unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package forwarding_unit_pkg;

    // NoType: instruction reads no register operand in ID.
    // Type1 : operands consumed in EX (forwarding covers everything but load-use).
    // Type2 : operands consumed in ID itself (branch compare), so EX/MEM producers stall.
    typedef enum logic [1:0] {
        NoType = 2'd0,
        Type1  = 2'd1,
        Type2  = 2'd2
    } forwarding_type_t;

endpackage

// File: rtl/hazard_unit_pkg.sv
// Types and helpers for the pipeline hazard controller.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package hazard_unit_pkg;

    typedef enum logic {
        Run     = 1'b0,
        MemWait = 1'b1
    } hazard_state_t;

    // True when a source register is produced by a live writer; x0 never matches.
    function automatic logic match(input logic [4:0] rs,
                                   input logic [4:0] rd,
                                   input logic       we);
        return (rs == rd) && (rd != 5'd0) && we;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
// Latency: count visible one cycle after the increment.
// Backpressure: none; inc_i is ignored once saturated.
//   clock, reset : clock and async active-high reset
//   clr_i, inc_i : synchronous clear and increment
//   q_o          : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (inc_i && (q_q != {W{1'b1}})) begin
            q_q <= q_q + W'(1);
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_unit.sv
// Per-stage stall/flush control for load-use, ID-operand and data-memory wait hazards.
// Latency: stall/flush outputs are combinational from state + inputs (same cycle).
// Backpressure: a data-memory wait holds every stage; a redirect seen mid-wait is deferred to the ack cycle.
//   Inputs : ID operand class/sources, EX/MEM destination info, flush_req_ex, trap_req, mem_req/mem_ack
//   Outputs: stall_if/id/ex/mem, flush_id/ex/mem, sticky mem_timeout
//   Optional: define HAZARD_PERF_EN to add stall_cycles (count of cycles with stall_if high)
module hazard_unit
    import forwarding_unit_pkg::*;
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  forwarding_type_t forwarding_type_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             reg_we_ex,
    input  logic             mem_rd_en_ex,
    input  logic             zicsr_ex,
    input  logic [4:0]       rd_mem,
    input  logic             reg_we_mem,
    input  logic             mem_rd_en_mem,
    input  logic             flush_req_ex,
    input  logic             trap_req,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    // Timeout is registered, so it must be armed on the cycle the count reaches MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(MEM_TIMEOUT - 1);

    hazard_state_t    state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] wait_cnt_q;

    logic operand_used;
    logic load_use;
    logic id_operand;
    logic data_hazard;
    logic wait_active;
    logic ack_cycle;

    // ---------------- hazard detection ----------------
    assign operand_used = (forwarding_type_id != NoType);

    assign load_use = mem_rd_en_ex && operand_used &&
                      (match(rs1_id, rd_ex, reg_we_ex) || match(rs2_id, rd_ex, reg_we_ex));

    // CSR results are forwarded to rs1 late enough that only rs2 needs a stall on them.
    assign id_operand = (forwarding_type_id == Type2) &&
                        (match(rs1_id, rd_ex, reg_we_ex && !zicsr_ex) ||
                         match(rs2_id, rd_ex, reg_we_ex) ||
                         match(rs1_id, rd_mem, reg_we_mem && mem_rd_en_mem) ||
                         match(rs2_id, rd_mem, reg_we_mem && mem_rd_en_mem));

    assign data_hazard = load_use || id_operand;

    // Stalls begin on the request cycle itself, not one cycle after entering MemWait.
    assign wait_active = !trap_req &&
                         (((state_q == Run) && mem_req && !mem_ack) ||
                          ((state_q == MemWait) && !mem_ack));

    assign ack_cycle = !trap_req && (state_q == MemWait) && mem_ack;

    // ---------------- state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= Run;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        if (trap_req) begin
            state_d = Run;
        end else begin
            case (state_q)
                Run:     if (mem_req && !mem_ack) state_d = MemWait;
                MemWait: if (mem_ack)             state_d = Run;
                default: state_d = Run;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        if (reset) begin
            // everything stays low while reset is held
        end else if (trap_req) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
        end else if (wait_active) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (flush_req_ex || (ack_cycle && flush_pend_q)) begin
            // Redirect squashes the hazarding instruction, so no stall is needed.
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (data_hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    // ---------------- pending redirect and timeout ----------------
    always_comb begin
        flush_pend_d = 1'b0;
        timeout_d    = timeout_q;
        if (trap_req) begin
            timeout_d = 1'b0;
        end else begin
            if (wait_active) begin
                flush_pend_d = flush_pend_q || flush_req_ex;
            end
            if (wait_active && (wait_cnt_q >= TIMEOUT_M1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_pend_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    // Counts wait cycles; any non-wait cycle (including a trap) clears it.
    sat_counter #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .clr_i (!wait_active),
        .inc_i (wait_active),
        .q_o   (wait_cnt_q)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else if (stall_if) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with MEM_TIMEOUT=3.
// Latency: checks sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_hazard_unit;
    import forwarding_unit_pkg::*;
    import hazard_unit_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    forwarding_type_t forwarding_type_id;
    logic [4:0]       rs1_id, rs2_id, rd_ex, rd_mem;
    logic             reg_we_ex, mem_rd_en_ex, zicsr_ex;
    logic             reg_we_mem, mem_rd_en_mem;
    logic             flush_req_ex, trap_req, mem_req, mem_ack;
    logic             stall_if, stall_id, stall_ex, stall_mem;
    logic             flush_id, flush_ex, flush_mem;
    logic             mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem}
    logic [6:0] outs;
    assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem};

    localparam logic [6:0] NONE  = 7'b000_0000;
    localparam logic [6:0] HAZ   = 7'b110_0010;
    localparam logic [6:0] WAIT  = 7'b111_1000;
    localparam logic [6:0] REDIR = 7'b000_0110;
    localparam logic [6:0] TRAP  = 7'b000_0111;

    always #5 clock = ~clock;

    hazard_unit #(
        .MEM_TIMEOUT (3)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .forwarding_type_id (forwarding_type_id),
        .rs1_id             (rs1_id),
        .rs2_id             (rs2_id),
        .rd_ex              (rd_ex),
        .reg_we_ex          (reg_we_ex),
        .mem_rd_en_ex       (mem_rd_en_ex),
        .zicsr_ex           (zicsr_ex),
        .rd_mem             (rd_mem),
        .reg_we_mem         (reg_we_mem),
        .mem_rd_en_mem      (mem_rd_en_mem),
        .flush_req_ex       (flush_req_ex),
        .trap_req           (trap_req),
        .mem_req            (mem_req),
        .mem_ack            (mem_ack),
        .stall_if           (stall_if),
        .stall_id           (stall_id),
        .stall_ex           (stall_ex),
        .stall_mem          (stall_mem),
        .flush_id           (flush_id),
        .flush_ex           (flush_ex),
        .flush_mem          (flush_mem),
        .mem_timeout        (mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        forwarding_type_id = NoType;
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0; rd_mem = 5'd0;
        reg_we_ex = 1'b0; mem_rd_en_ex = 1'b0; zicsr_ex = 1'b0;
        reg_we_mem = 1'b0; mem_rd_en_mem = 1'b0;
        flush_req_ex = 1'b0; trap_req = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_use_inputs();
        forwarding_type_id = Type1;
        mem_rd_en_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
    endtask

    initial begin
        // ---------------- reset ----------------
        reset = 1'b1;
        idle();
        trap_req = 1'b1; flush_req_ex = 1'b1; mem_req = 1'b1;
        load_use_inputs();
        #3;
        check_eq("reset_outs", 32'(outs), 32'(NONE));
        check_eq("reset_timeout", 32'(mem_timeout), 32'd0);
        #9;
        reset = 1'b0;
        idle();

        // ---------------- load-use ----------------
        tick(); load_use_inputs();
        @(negedge clock); check_eq("load_use", 32'(outs), 32'(HAZ));
        tick();
        @(negedge clock); check_eq("load_use_clear", 32'(outs), 32'(NONE));
        tick(); load_use_inputs(); rd_ex = 5'd0; rs1_id = 5'd0;
        @(negedge clock); check_eq("load_use_x0", 32'(outs), 32'(NONE));
        tick(); load_use_inputs(); forwarding_type_id = NoType;
        @(negedge clock); check_eq("load_use_notype", 32'(outs), 32'(NONE));
        tick(); load_use_inputs(); rs1_id = 5'd0; rs2_id = 5'd5;
        @(negedge clock); check_eq("load_use_rs2", 32'(outs), 32'(HAZ));

        // ---------------- branch after load ----------------
        tick(); forwarding_type_id = Type2; rs2_id = 5'd7;
        rd_ex = 5'd7; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
        @(negedge clock); check_eq("br_load_c1", 32'(outs), 32'(HAZ));
        tick(); forwarding_type_id = Type2; rs2_id = 5'd7;
        rd_mem = 5'd7; reg_we_mem = 1'b1; mem_rd_en_mem = 1'b1;
        @(negedge clock); check_eq("br_load_c2", 32'(outs), 32'(HAZ));
        tick(); forwarding_type_id = Type2; rs2_id = 5'd7;
        @(negedge clock); check_eq("br_load_c3", 32'(outs), 32'(NONE));

        // CSR writer in EX: exempt on rs1, hazard on rs2
        tick(); forwarding_type_id = Type2; rs1_id = 5'd3;
        rd_ex = 5'd3; reg_we_ex = 1'b1; zicsr_ex = 1'b1;
        @(negedge clock); check_eq("csr_rs1", 32'(outs), 32'(NONE));
        tick(); forwarding_type_id = Type2; rs2_id = 5'd3;
        rd_ex = 5'd3; reg_we_ex = 1'b1; zicsr_ex = 1'b1;
        @(negedge clock); check_eq("csr_rs2", 32'(outs), 32'(HAZ));
        tick(); forwarding_type_id = Type2; rs1_id = 5'd9;
        rd_ex = 5'd9; reg_we_ex = 1'b1;
        @(negedge clock); check_eq("alu_rs1", 32'(outs), 32'(HAZ));

        // ---------------- redirect beats data hazard ----------------
        tick(); load_use_inputs(); flush_req_ex = 1'b1;
        @(negedge clock); check_eq("redir_over_haz", 32'(outs), 32'(REDIR));

        // ---------------- req+ack same cycle in Run ----------------
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        @(negedge clock); check_eq("req_ack_run", 32'(outs), 32'(NONE));
        tick();
        @(negedge clock); check_eq("req_ack_after", 32'(outs), 32'(NONE));

        // ---------------- memory wait with redirect, timeout ----------------
        for (int i = 0; i < 4; i++) begin
            tick(); mem_req = 1'b1; flush_req_ex = (i == 1);
            @(negedge clock);
            check_eq($sformatf("wait_c%0d", i + 1), 32'(outs), 32'(WAIT));
            check_eq($sformatf("wait_tmo_c%0d", i + 1), 32'(mem_timeout), (i == 3) ? 32'd1 : 32'd0);
        end
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        @(negedge clock); check_eq("wait_ack_flush", 32'(outs), 32'(REDIR));
        check_eq("tmo_after_ack", 32'(mem_timeout), 32'd1);
        tick();
        @(negedge clock); check_eq("wait_done", 32'(outs), 32'(NONE));
        check_eq("tmo_sticky", 32'(mem_timeout), 32'd1);
        tick(); trap_req = 1'b1;
        @(negedge clock); check_eq("trap_outs", 32'(outs), 32'(TRAP));
        tick();
        @(negedge clock); check_eq("tmo_cleared", 32'(mem_timeout), 32'd0);

        // wait counter restarts on each wait: two 2-cycle waits never time out
        for (int r = 0; r < 2; r++) begin
            tick(); mem_req = 1'b1;
            tick(); mem_req = 1'b1;
            tick(); mem_req = 1'b1; mem_ack = 1'b1;
            @(negedge clock); check_eq("short_wait_ack", 32'(outs), 32'(NONE));
        end
        tick();
        @(negedge clock); check_eq("cnt_cleared_tmo", 32'(mem_timeout), 32'd0);

        // ---------------- redirect on the ack cycle ----------------
        tick(); mem_req = 1'b1;
        @(negedge clock); check_eq("ackflush_wait", 32'(outs), 32'(WAIT));
        tick(); mem_req = 1'b1; mem_ack = 1'b1; flush_req_ex = 1'b1;
        @(negedge clock); check_eq("ackflush_ack", 32'(outs), 32'(REDIR));
        tick();
        @(negedge clock); check_eq("ackflush_done", 32'(outs), 32'(NONE));

        // ---------------- priority: trap over wait, redirect and hazard ----------------
        tick(); mem_req = 1'b1; flush_req_ex = 1'b1;
        @(negedge clock); check_eq("prio_wait", 32'(outs), 32'(WAIT));
        tick(); load_use_inputs(); mem_req = 1'b1; flush_req_ex = 1'b1; trap_req = 1'b1;
        @(negedge clock); check_eq("prio_trap", 32'(outs), 32'(TRAP));
        tick();
        @(negedge clock); check_eq("prio_run", 32'(outs), 32'(NONE));
        // pending redirect was dropped by the trap
        tick(); mem_req = 1'b1;
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        @(negedge clock); check_eq("trap_drops_pend", 32'(outs), 32'(NONE));

        // ---------------- reset mid-wait ----------------
        tick(); mem_req = 1'b1; flush_req_ex = 1'b1;
        @(negedge clock); check_eq("rst_wait", 32'(outs), 32'(WAIT));
        tick();
        reset = 1'b1; #2; reset = 1'b0;
        @(negedge clock); check_eq("rst_to_run", 32'(outs), 32'(NONE));
        tick(); mem_req = 1'b1;
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        @(negedge clock); check_eq("rst_drops_pend", 32'(outs), 32'(NONE));

`ifdef HAZARD_PERF_EN
        // ---------------- stall cycle counter ----------------
        tick();
        reset = 1'b1; #2; reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); mem_req = 1'b1;
        end
        tick(); mem_req = 1'b1; mem_ack = 1'b1;
        @(negedge clock); check_eq("perf_count", stall_cycles, 32'd10);
        tick(); reset = 1'b1;
        #1; check_eq("perf_reset", stall_cycles, 32'd0);
        #1; reset = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
